// File: rtl/data_memory_bytelane_pkg.sv
// Shared definitions for the byte-lane data memory:
// RV32 load/store funct3 codes and controller states.
package data_memory_bytelane_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_bytelane_lsu_byte_align.sv
// Combinational byte-lane steering for RV32 loads and stores,
// plus the misaligned / illegal-funct3 flag.
module data_memory_bytelane_lsu_byte_align
    import data_memory_bytelane_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  a,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        err
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign bsel = word[{a, 3'b000} +: 8];
    assign hsel = a[1] ? word[31:16] : word[15:0];

    always_comb begin
        be       = 4'b0000;
        wdata_sh = 32'h0;
        rdata    = 32'h0;
        err      = 1'b0;
        // Store data is replicated across lanes; be picks the live ones.
        unique case (funct3)
            F3_B: begin
                be       = 4'b0001 << a;
                wdata_sh = {4{wdata[7:0]}};
                rdata    = {{24{bsel[7]}}, bsel};
            end
            F3_BU: begin
                err   = write;
                rdata = {24'h0, bsel};
            end
            F3_H: begin
                err      = a[0];
                be       = a[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                rdata    = {{16{hsel[15]}}, hsel};
            end
            F3_HU: begin
                err   = a[0] | write;
                rdata = {16'h0, hsel};
            end
            F3_W: begin
                err      = (a != 2'b00);
                be       = 4'b1111;
                wdata_sh = wdata;
                rdata    = word;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressable RV32 data memory, single outstanding request,
// configurable read latency and post-reset clear sweep.
module data_memory_bytelane
    import data_memory_bytelane_pkg::*;
#(
    parameter int MEMORY_SIZE    = 4096,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int DEPTH = MEMORY_SIZE / 4;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    state_t        state, state_nx;
    logic [AW-1:0] clr_idx;
    logic [2:0]    cnt;
    logic [AW-1:0] idx;
    logic          accept, in_range, lane_err, err;
    logic [3:0]    be;
    logic [31:0]   wsh, ld, word, rd_val;
    logic [31:0]   pend_rdata;
    logic          pend_err;

    assign req_ready = (state == S_IDLE) && !reset;
    assign busy      = (state == S_CLEAR);
    assign accept    = req_valid && req_ready;
    assign idx       = req_address[AW+1:2];
    assign in_range  = req_address < 32'(MEMORY_SIZE);
    assign word      = mem[idx];
    assign err       = lane_err || !in_range;
    assign rd_val    = (err || req_write) ? 32'h0 : ld;

    data_memory_bytelane_lsu_byte_align u_align (
        .funct3   (req_funct3),
        .write    (req_write),
        .a        (req_address[1:0]),
        .wdata    (req_wdata),
        .word     (word),
        .be       (be),
        .wdata_sh (wsh),
        .rdata    (ld),
        .err      (lane_err)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR:
                if (clr_idx == AW'(DEPTH - 1)) state_nx = S_IDLE;
            S_IDLE:
                if (accept && READ_LATENCY > 1) state_nx = S_WAIT;
            S_WAIT:
                if (cnt == 3'd1) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clr_idx    <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_error  <= 1'b0;
            pend_rdata <= 32'h0;
            pend_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;
            if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
            if (accept) begin
                if (READ_LATENCY == 1) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_val;
                    rsp_error <= err;
                end else begin
                    pend_rdata <= rd_val;
                    pend_err   <= err;
                    cnt        <= 3'(READ_LATENCY - 1);
                end
            end
            if (state == S_WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == 3'd1) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= pend_rdata;
                    rsp_error <= pend_err;
                end
            end
        end
    end

    // Array has no reset; the sweep owns it until IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLEAR) begin
                mem[clr_idx] <= 32'h0;
            end else if (accept && req_write && !err) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Self-checking bench: directed scenarios plus random traffic
// compared against a little-endian byte-array reference model.
module tb_data_memory_bytelane;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;

    logic        valid1, ready1, rv1, err1, busy1;
    logic [31:0] rd1;
    logic        valid3, ready3, rv3, err3, busy3;
    logic [31:0] rd3;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [2][4096];

    always #5 clk = ~clk;

    data_memory_bytelane #(
        .MEMORY_SIZE(4096), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(valid1), .req_ready(ready1),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_error(err1),
        .busy(busy1)
    );

    data_memory_bytelane #(
        .MEMORY_SIZE(4096), .READ_LATENCY(3), .CLEAR_ON_RESET(1)
    ) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(valid3), .req_ready(ready3),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_error(err3),
        .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4096; i++) mdl[d][i] = 8'h00;
    endfunction

    // Memory as a plain byte array; access size from funct3.
    function automatic void model(input int d, input bit wr,
                                  input bit [2:0] f3, input bit [31:0] a,
                                  input bit [31:0] wd,
                                  output bit [31:0] rd, output bit er);
        int sz;
        sz = (f3 == 0 || f3 == 4) ? 1 :
             (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
        rd = 32'h0;
        er = (sz == 0) || (wr && f3[2]) || (a >= 4096);
        if (!er && (a % sz) != 0) er = 1'b1;
        if (er) return;
        for (int i = 0; i < sz; i++) begin
            if (wr) mdl[d][a + i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mdl[d][a + i];
        end
        if (!wr && f3 == 3'd0 && rd[7])  rd[31:8]  = 24'hFFFFFF;
        if (!wr && f3 == 3'd1 && rd[15]) rd[31:16] = 16'hFFFF;
    endfunction

    task automatic do_req(input int d, input bit wr, input bit [2:0] f3,
                          input bit [31:0] a, input bit [31:0] wd,
                          output bit [31:0] rd_o, output bit er_o);
        bit [31:0] erd;
        bit        eer;
        bit        got;
        int        n;
        @(negedge clk);
        req_write = wr; req_funct3 = f3;
        req_address = a; req_wdata = wd;
        if (d == 0) valid1 = 1'b1; else valid3 = 1'b1;
        n = 0;
        while (!(d == 0 ? ready1 : ready3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        model(d, wr, f3, a, wd, erd, eer);
        #1;
        valid1 = 1'b0; valid3 = 1'b0;
        n = 0; got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            got = (d == 0) ? rv1 : rv3;
            n++;
        end
        chk("rsp_timeout", 32'(got), 32'd1);
        rd_o = (d == 0) ? rd1 : rd3;
        er_o = (d == 0) ? err1 : err3;
        chk($sformatf("rdata d%0d f3=%0d a=%h", d, f3, a), rd_o, erd);
        chk($sformatf("error d%0d f3=%0d a=%h", d, f3, a), 32'(er_o), 32'(eer));
    endtask

    task automatic wait_clear(input string tag, output int n);
        n = 0;
        while (busy1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_ready"}, 32'(ready1), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] rd;
        bit        er;
        int        n, pulses;
        bit [31:0] erd;
        bit        eer;

        reset = 1'b1; valid1 = 1'b0; valid3 = 1'b0;
        req_write = 1'b0; req_funct3 = 3'd0;
        req_address = 32'h0; req_wdata = 32'h0;
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rv1), 32'd0);
        chk("rst_rdata", rd1, 32'h0);
        chk("rst_error", 32'(err1), 32'd0);
        chk("rst_ready", 32'(ready1), 32'd0);

        // Clear sweep length
        reset = 1'b0;
        chk("clr_ready_low", 32'(ready1), 32'd0);
        wait_clear("clr", n);
        chk("clr_cycles", 32'(n), 32'd1024);
        chk("clr_busy3", 32'(busy3), 32'd0);
        do_req(0, 0, 3'b010, 32'h0FFC, 0, rd, er);
        chk("lw_top_zero", rd, 32'h0);

        // Sign/zero extension
        do_req(0, 1, 3'b010, 32'h10, 32'h8000_00F1, rd, er);
        do_req(0, 0, 3'b000, 32'h10, 0, rd, er);
        chk("lb", rd, 32'hFFFF_FFF1);
        do_req(0, 0, 3'b100, 32'h10, 0, rd, er);
        chk("lbu", rd, 32'h0000_00F1);
        do_req(0, 0, 3'b001, 32'h12, 0, rd, er);
        chk("lh", rd, 32'hFFFF_8000);
        do_req(0, 0, 3'b101, 32'h12, 0, rd, er);
        chk("lhu", rd, 32'h0000_8000);

        // Partial stores
        do_req(0, 1, 3'b010, 32'h20, 32'h1122_3344, rd, er);
        do_req(0, 1, 3'b000, 32'h21, 32'h0000_00AA, rd, er);
        do_req(0, 0, 3'b010, 32'h20, 0, rd, er);
        chk("sb_merge", rd, 32'h1122_AA44);
        do_req(0, 1, 3'b001, 32'h22, 32'h0000_BEEF, rd, er);
        do_req(0, 0, 3'b010, 32'h20, 0, rd, er);
        chk("sh_merge", rd, 32'hBEEF_AA44);

        // Error cases
        do_req(0, 1, 3'b010, 32'h0, 32'hCAFE_BABE, rd, er);
        do_req(0, 0, 3'b010, 32'h6, 0, rd, er);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rd", rd, 32'h0);
        do_req(0, 1, 3'b001, 32'h3, 32'h1234, rd, er);
        chk("sh_mis_err", 32'(er), 32'd1);
        do_req(0, 0, 3'b010, 32'h0, 0, rd, er);
        chk("sh_mis_kept", rd, 32'hCAFE_BABE);
        do_req(0, 0, 3'b010, 32'h1000, 0, rd, er);
        chk("oob_err", 32'(er), 32'd1);
        do_req(0, 0, 3'b011, 32'h0, 0, rd, er);
        chk("f3_011_err", 32'(er), 32'd1);
        do_req(0, 1, 3'b100, 32'h0, 32'h55, rd, er);
        chk("sbu_err", 32'(er), 32'd1);

        // Latency 3 timing
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h0;
        valid3 = 1'b1;
        chk("l3_ready0", 32'(ready3), 32'd1);
        @(posedge clk);
        model(1, 0, 3'b010, 32'h0, 0, erd, eer);
        #1 valid3 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("l3_wait_rv%0d", k), 32'(rv3), 32'd0);
            chk($sformatf("l3_wait_rdy%0d", k), 32'(ready3), 32'd0);
        end
        @(negedge clk);
        chk("l3_rv", 32'(rv3), 32'd1);
        chk("l3_rdy", 32'(ready3), 32'd1);
        chk("l3_rd", rd3, erd);
        @(negedge clk);
        chk("l3_pulse", 32'(rv3), 32'd0);

        // Back-to-back at latency 1
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) chk("b2b_ready", 32'(ready1), 32'd1);
            else chk($sformatf("b2b_rv%0d", k), 32'(rv1), 32'd1);
            req_write   = (k < 4);
            req_funct3  = 3'b010;
            req_address = (k < 4) ? 32'(32'h40 + 4 * k) : 32'h44;
            req_wdata   = 32'hA5A5_0000 + 32'(k);
            valid1      = 1'b1;
            model(0, req_write, 3'b010, req_address, req_wdata, erd, eer);
        end
        @(negedge clk);
        valid1 = 1'b0;
        chk("b2b_rv5", 32'(rv1), 32'd1);
        chk("b2b_rd", rd1, erd);
        chk("b2b_rd_const", rd1, 32'hA5A5_0001);
        @(negedge clk);
        chk("b2b_end", 32'(rv1), 32'd0);

        // Random traffic on both instances
        for (int i = 0; i < 200; i++) begin
            bit [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? 32'(4096 + $urandom_range(0, 63))
                                             : 32'($urandom_range(0, 127));
            do_req((i % 4 == 3) ? 1 : 0, 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), a, $urandom, rd, er);
        end

        // Reset while waiting for a response
        do_req(1, 1, 3'b010, 32'h80, 32'h1234_5678, rd, er);
        do_req(0, 1, 3'b010, 32'h80, 32'h1234_5678, rd, er);
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h80;
        valid3 = 1'b1;
        @(posedge clk);
        #1 valid3 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        chk("rst_wait_busy", 32'(busy3), 32'd1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (rv3) pulses++;
            @(negedge clk);
        end
        chk("rst_wait_norsp", 32'(pulses), 32'd0);
        wait_clear("reclr", n);
        do_req(1, 0, 3'b010, 32'h80, 0, rd, er);
        chk("reclr_d3", rd, 32'h0);
        do_req(0, 0, 3'b010, 32'h80, 0, rd, er);
        chk("reclr_d1", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
